// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable 50%-duty clock divider; new half-periods apply only at full-period boundaries
module clk_div_ctrl #(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] RESET_HALF = 16'd4
) (
    input  logic             clk_source,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             clk_tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_half
);
    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, shadow_q, shadow_d;
    logic             out_q, out_d, tick_q, tick_d, busy_q, busy_d;
    logic             xfer, wrap;
    assign cfg_ready = state_q != PEND;
    assign xfer      = cfg_valid && cfg_ready;
    assign wrap      = cnt_q == half_q - CNT_W'(1);
    assign clk_out   = out_q;
    assign clk_tick  = tick_q;
    assign busy      = busy_q;
    assign cur_half  = half_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        tick_d   = 1'b0;
        busy_d   = busy_q;
        if (state_q == STOP) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (xfer) begin
                half_d  = cfg_half;
                state_d = cfg_half != '0 ? RUN : STOP;
            end
        end else begin
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
            out_d  = wrap ? !out_q : out_q;
            tick_d = wrap && !out_q;
            if (state_q == RUN && xfer) begin
                shadow_d = cfg_half;
                busy_d   = 1'b1;
                state_d  = PEND;
            end
            // falling edge closes the period: safe point to swap in the shadow value
            if (state_q == PEND && wrap && out_q) begin
                half_d  = shadow_q;
                busy_d  = 1'b0;
                state_d = shadow_q == '0 ? STOP : RUN;
            end
        end
    end
    always_ff @(posedge clk_source or posedge rst) begin
        if (rst) begin
            state_q  <= RESET_HALF != '0 ? RUN : STOP;
            cnt_q    <= '0;
            half_q   <= RESET_HALF;
            shadow_q <= '0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed stimulus with a tick-time scoreboard checked by an independent monitor
module tb_clk_div_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_half = '0;
    logic        cfg_ready, clk_out, clk_tick, busy;
    logic [15:0] cur_half;
    int          cyc;
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_q[$];

    clk_div_ctrl dut (
        .clk_source(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_half(cfg_half),
        .cfg_ready(cfg_ready),
        .clk_out(clk_out),
        .clk_tick(clk_tick),
        .busy(busy),
        .cur_half(cur_half)
    );

    always #5 clk = !clk;

    // cyc = number of rising edges since the last reset release
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (!rst && clk_tick) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tick_unexpected: tick at cyc %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc != e || !clk_out) begin
                    n_fail++;
                    $display("FAIL tick_time: tick at cyc %0d clk_out %0b, expected cyc %0d clk_out 1", cyc, clk_out, e);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 200000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < n) chk("wait_bound", cyc, n);
    endtask

    task automatic send(input logic [15:0] h, output int te);
        int g = 0;
        cfg_valid = 1'b1;
        cfg_half  = h;
        while (!cfg_ready && g < 200000) begin
            @(negedge clk);
            g++;
        end
        if (!cfg_ready) chk("send_ready_bound", 0, 1);
        te = cyc + 1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int te, stall;
        // reset behaviour with RESET_HALF = 4
        exp_q.push_back(4);
        exp_q.push_back(12);
        release_rst();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", clk_tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_cur_half", cur_half, 4);
        wait_cyc(3);
        chk("low_phase_end", clk_out, 0);
        wait_cyc(8);
        chk("first_fall", clk_out, 0);
        // half 4 -> 2 offered mid high phase
        wait_cyc(14);
        exp_q.push_back(18);
        exp_q.push_back(22);
        send(16'd2, te);
        chk("b_xfer_edge", te, 15);
        chk("b_busy", busy, 1);
        chk("b_ready", cfg_ready, 0);
        chk("b_old_half", cur_half, 4);
        wait_cyc(16);
        chk("b_new_half", cur_half, 2);
        chk("b_busy_clr", busy, 0);
        chk("b_ready_back", cfg_ready, 1);
        chk("b_fall", clk_out, 0);
        // stop via 0, then restart with 3
        wait_cyc(24);
        exp_q.push_back(26);
        send(16'd0, te);
        wait_cyc(27);
        chk("c_busy_pend", busy, 1);
        wait_cyc(29);
        chk("c_stop_out", clk_out, 0);
        chk("c_stop_half", cur_half, 0);
        chk("c_stop_ready", cfg_ready, 1);
        chk("c_stop_busy", busy, 0);
        wait_cyc(40);
        chk("c_still_stopped", clk_out, 0);
        exp_q.push_back(44);
        exp_q.push_back(50);
        send(16'd3, te);
        chk("c_run_half", cur_half, 3);
        chk("c_run_busy", busy, 0);
        // divide-by-2, then maximum half-period
        wait_cyc(50);
        for (int i = 54; i <= 62; i += 2) exp_q.push_back(i);
        send(16'd1, te);
        wait_cyc(55);
        chk("d_half1", cur_half, 1);
        chk("d_half1_low", clk_out, 0);
        wait_cyc(61);
        exp_q.push_back(65598);
        send(16'hFFFF, te);
        wait_cyc(64);
        chk("d_max_half", cur_half, 65535);
        chk("d_max_busy", busy, 0);
        wait_cyc(65597);
        chk("d_max_low", clk_out, 0);
        wait_cyc(65600);
        chk("d_max_high", clk_out, 1);
        chk("d_queue_empty", exp_q.size(), 0);
        // async reset mid high phase
        #2 rst = 1'b1;
        #1 chk("d_rst_async_out", clk_out, 0);
        chk("d_rst_half", cur_half, 4);
        exp_q.push_back(4);
        exp_q.push_back(13);
        exp_q.push_back(25);
        exp_q.push_back(39);
        release_rst();
        // back-to-back 5 then 7 with valid held
        wait_cyc(5);
        chk("e_ready_first", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_half  = 16'd5;
        @(negedge clk);
        cfg_half = 16'd7;
        stall = 0;
        while (!cfg_ready && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        chk("e_stall_cycles", stall, 2);
        chk("e_half5", cur_half, 5);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("e_busy7", busy, 1);
        wait_cyc(17);
        chk("e_still5", cur_half, 5);
        wait_cyc(18);
        chk("e_half7", cur_half, 7);
        chk("e_busy_clr", busy, 0);
        // reset with a pending change during the high phase
        wait_cyc(40);
        send(16'd2, te);
        wait_cyc(42);
        chk("f_busy", busy, 1);
        chk("f_high", clk_out, 1);
        #2 rst = 1'b1;
        #1 chk("f_rst_out", clk_out, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_ready", cfg_ready, 1);
        exp_q.push_back(4);
        exp_q.push_back(12);
        exp_q.push_back(20);
        release_rst();
        wait_cyc(13);
        chk("f_half_kept", cur_half, 4);
        chk("f_busy_after", busy, 0);
        wait_cyc(21);
        chk("f_half_final", cur_half, 4);
        chk("f_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
